// File: rtl/tlb_search_arbiter.sv
// Shares one TLB search port among tlbp > data > inst (starved inst overrides data); result registered to winner 1 cycle later.
// Backpressure: a requester holds req/key until its combinational gnt. Optional TLB_ARB_PERF_EN adds perf counters.
module tlb_search_arbiter #(
  parameter int TLBNUM       = 16,
  parameter int STARVE_LIMIT = 4,
  localparam int IW          = $clog2(TLBNUM)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          inst_req_i,
  input  logic [18:0]   inst_vpn_i,
  input  logic          inst_odd_i,
  input  logic [7:0]    inst_asid_i,
  output logic          inst_gnt_o,
  output logic          inst_rvalid_o,
  input  logic          data_req_i,
  input  logic [18:0]   data_vpn_i,
  input  logic          data_odd_i,
  input  logic [7:0]    data_asid_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  input  logic          tlbp_req_i,
  input  logic [18:0]   tlbp_vpn_i,
  input  logic          tlbp_odd_i,
  input  logic [7:0]    tlbp_asid_i,
  output logic          tlbp_gnt_o,
  output logic          tlbp_rvalid_o,
  output logic          r_found_o,
  output logic [IW-1:0] r_index_o,
  output logic [19:0]   r_pfn_o,
  output logic [2:0]    r_c_o,
  output logic          r_d_o,
  output logic          r_v_o,
  output logic [18:0]   s_vpn_o,
  output logic          s_odd_o,
  output logic [7:0]    s_asid_o,
  input  logic          s_found_i,
  input  logic [IW-1:0] s_index_i,
  input  logic [19:0]   s_pfn_i,
  input  logic [2:0]    s_c_i,
  input  logic          s_d_i,
  input  logic          s_v_i
`ifdef TLB_ARB_PERF_EN
  ,
  output logic [31:0]   perf_conflict_o,
  output logic [31:0]   perf_starve_o
`endif
);

  typedef struct packed {
    logic          found;
    logic [IW-1:0] index;
    logic [19:0]   pfn;
    logic [2:0]    c;
    logic          d;
    logic          v;
  } res_t;

  logic [3:0] starve_q, starve_d;
  logic       inst_rv_q, data_rv_q, tlbp_rv_q;
  res_t       res_q;
  logic       inst_ok, inst_over, any_gnt;

  assign inst_ok   = inst_req_i & ~flush_i & ~rst_i;
  assign inst_over = (starve_q == 4'(STARVE_LIMIT));
  assign any_gnt   = inst_gnt_o | data_gnt_o | tlbp_gnt_o;

  always_comb begin
    tlbp_gnt_o = 1'b0;
    data_gnt_o = 1'b0;
    inst_gnt_o = 1'b0;
    if (!rst_i) begin
      if (tlbp_req_i)                          tlbp_gnt_o = 1'b1;
      else if (data_req_i && !(inst_ok && inst_over)) data_gnt_o = 1'b1;
      else if (inst_ok)                        inst_gnt_o = 1'b1;
    end
  end

  always_comb begin
    s_vpn_o  = '0;
    s_odd_o  = 1'b0;
    s_asid_o = '0;
    if (tlbp_gnt_o) begin
      s_vpn_o = tlbp_vpn_i; s_odd_o = tlbp_odd_i; s_asid_o = tlbp_asid_i;
    end else if (data_gnt_o) begin
      s_vpn_o = data_vpn_i; s_odd_o = data_odd_i; s_asid_o = data_asid_i;
    end else if (inst_gnt_o) begin
      s_vpn_o = inst_vpn_i; s_odd_o = inst_odd_i; s_asid_o = inst_asid_i;
    end
  end

  // Counts consecutive cycles a live inst request lost arbitration.
  always_comb begin
    starve_d = starve_q;
    if (flush_i || !inst_req_i || inst_gnt_o) starve_d = 4'd0;
    else if (!inst_over)                      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q  <= 4'd0;
      inst_rv_q <= 1'b0;
      data_rv_q <= 1'b0;
      tlbp_rv_q <= 1'b0;
      res_q     <= '0;
    end else begin
      starve_q  <= starve_d;
      inst_rv_q <= inst_gnt_o;
      data_rv_q <= data_gnt_o;
      tlbp_rv_q <= tlbp_gnt_o;
      if (any_gnt) res_q <= '{s_found_i, s_index_i, s_pfn_i, s_c_i, s_d_i, s_v_i};
    end
  end

  // Outputs are masked during reset so a mid-flight result never escapes.
  assign inst_rvalid_o = inst_rv_q & ~flush_i & ~rst_i;
  assign data_rvalid_o = data_rv_q & ~rst_i;
  assign tlbp_rvalid_o = tlbp_rv_q & ~rst_i;
  assign r_found_o = res_q.found & ~rst_i;
  assign r_index_o = rst_i ? '0 : res_q.index;
  assign r_pfn_o   = rst_i ? '0 : res_q.pfn;
  assign r_c_o     = rst_i ? '0 : res_q.c;
  assign r_d_o     = res_q.d & ~rst_i;
  assign r_v_o     = res_q.v & ~rst_i;

`ifdef TLB_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_starve_q;
  logic        conflict, starve_fire;

  assign conflict    = (inst_req_i & data_req_i) | (inst_req_i & tlbp_req_i) | (data_req_i & tlbp_req_i);
  assign starve_fire = inst_gnt_o & data_req_i & inst_over;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_conflict_q <= 32'd0;
      perf_starve_q   <= 32'd0;
    end else begin
      if (conflict)    perf_conflict_q <= perf_conflict_q + 32'd1;
      if (starve_fire) perf_starve_q   <= perf_starve_q + 32'd1;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_starve_o   = perf_starve_q;
`endif

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Bench for tlb_search_arbiter: directed scenarios plus a short random tail, checked every cycle against a behavioural model.
module tb_tlb_search_arbiter;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1, flush = 1'b0;
  logic inst_req = 1'b0, data_req = 1'b0, tlbp_req = 1'b0;
  logic [18:0] inst_vpn = 19'h00400, data_vpn = 19'h1A2B3, tlbp_vpn = 19'h07777;
  logic inst_odd = 1'b0, data_odd = 1'b1, tlbp_odd = 1'b0;
  logic [7:0] inst_asid = 8'h11, data_asid = 8'h22, tlbp_asid = 8'h33;
  logic inst_gnt, data_gnt, tlbp_gnt, inst_rvalid, data_rvalid, tlbp_rvalid;
  logic r_found, r_d, r_v;
  logic [3:0] r_index;
  logic [19:0] r_pfn;
  logic [2:0] r_c;
  logic [18:0] s_vpn;
  logic s_odd;
  logic [7:0] s_asid;
  res_t tlb_r;
`ifdef TLB_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_starve;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic res_t tlb_fn(input logic [18:0] vpn, input logic odd, input logic [7:0] asid);
    res_t r;
    if (vpn == 19'h00400 && !odd) r = '{1'b1, 4'h5, 20'h01234, 3'd3, 1'b1, 1'b1};
    else r = '{vpn[0], vpn[3:0], {vpn, odd} ^ 20'h5A5A5, asid[2:0], odd, ~vpn[1]};
    return r;
  endfunction

  always_comb tlb_r = tlb_fn(s_vpn, s_odd, s_asid);

  tlb_search_arbiter #(.TLBNUM(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .inst_req_i(inst_req), .inst_vpn_i(inst_vpn), .inst_odd_i(inst_odd), .inst_asid_i(inst_asid),
    .inst_gnt_o(inst_gnt), .inst_rvalid_o(inst_rvalid),
    .data_req_i(data_req), .data_vpn_i(data_vpn), .data_odd_i(data_odd), .data_asid_i(data_asid),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .tlbp_req_i(tlbp_req), .tlbp_vpn_i(tlbp_vpn), .tlbp_odd_i(tlbp_odd), .tlbp_asid_i(tlbp_asid),
    .tlbp_gnt_o(tlbp_gnt), .tlbp_rvalid_o(tlbp_rvalid),
    .r_found_o(r_found), .r_index_o(r_index), .r_pfn_o(r_pfn), .r_c_o(r_c), .r_d_o(r_d), .r_v_o(r_v),
    .s_vpn_o(s_vpn), .s_odd_o(s_odd), .s_asid_o(s_asid),
    .s_found_i(tlb_r.found), .s_index_i(tlb_r.index), .s_pfn_i(tlb_r.pfn),
    .s_c_i(tlb_r.c), .s_d_i(tlb_r.d), .s_v_i(tlb_r.v)
`ifdef TLB_ARB_PERF_EN
    , .perf_conflict_o(perf_conflict), .perf_starve_o(perf_starve)
`endif
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: who waits for a result, that result, the last shown result, inst's losing streak.
  int   m_pend = 0;
  res_t m_pres = '0;
  res_t m_hold = '0;
  int   m_wait = 0;
  int   win;
  logic iok;
  logic [2:0] e_gnt, e_rv;
  logic [27:0] e_key;
  res_t e_res;

  always @(negedge clk) begin
    if (rst) begin
      win = 0; e_key = '0; e_rv = 3'b000; e_res = '0;
    end else begin
      iok = inst_req && !flush;
      if (tlbp_req) win = 3;
      else if (data_req && !(iok && m_wait >= LIMIT)) win = 2;
      else if (iok) win = 1;
      else win = 0;
      case (win)
        3: e_key = {tlbp_vpn, tlbp_odd, tlbp_asid};
        2: e_key = {data_vpn, data_odd, data_asid};
        1: e_key = {inst_vpn, inst_odd, inst_asid};
        default: e_key = '0;
      endcase
      e_rv = 3'b000;
      if (m_pend == 1 && !flush) e_rv = 3'b001;
      if (m_pend == 2) e_rv = 3'b010;
      if (m_pend == 3) e_rv = 3'b100;
      e_res = (m_pend != 0) ? m_pres : m_hold;
    end
    e_gnt = (win == 0) ? 3'b000 : 3'(1 << (win - 1));
    check("gnt", {61'd0, tlbp_gnt, data_gnt, inst_gnt}, {61'd0, e_gnt});
    check("s_key", {36'd0, s_vpn, s_odd, s_asid}, {36'd0, e_key});
    check("rvalid", {61'd0, tlbp_rvalid, data_rvalid, inst_rvalid}, {61'd0, e_rv});
    check("r_res", {34'd0, r_found, r_index, r_pfn, r_c, r_d, r_v}, {34'd0, e_res});
    if (rst) begin
      m_pend = 0; m_hold = '0; m_wait = 0;
    end else begin
      m_hold = e_res;
      m_pend = win;
      m_pres = tlb_fn(e_key[27:9], e_key[8], e_key[7:0]);
      if (flush || !inst_req || win == 1) m_wait = 0;
      else m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
    end
  end

  task automatic cyc(input logic r, input logic f, input logic i, input logic d, input logic t);
    @(posedge clk);
    #1;
    rst = r; flush = f; inst_req = i; data_req = d; tlbp_req = t;
  endtask

  initial begin
    // Reset with every request raised: nothing may be granted.
    cyc(1, 0, 1, 1, 1);
    @(negedge clk);
    check("rst_gnt", {tlbp_gnt, data_gnt, inst_gnt}, 3'b000);
    check("rst_skey", {s_vpn, s_odd, s_asid}, 28'd0);
    check("rst_rfound", r_found, 1'b0);

    // Lone inst hit.
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    check("inst_gnt", inst_gnt, 1'b1);
    check("inst_svpn", s_vpn, 19'h00400);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("inst_rvalid", inst_rvalid, 1'b1);
    check("inst_rfound", r_found, 1'b1);
    check("inst_rpfn", r_pfn, 20'h01234);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rvalid_pulse", inst_rvalid, 1'b0);
    check("r_hold", r_pfn, 20'h01234);

    // Three-way contention resolves tlbp, data, inst.
    cyc(0, 0, 1, 1, 1);
    @(negedge clk);
    check("tri_n0", {tlbp_gnt, data_gnt, inst_gnt}, 3'b100);
    cyc(0, 0, 1, 1, 0);
    @(negedge clk);
    check("tri_n1", {tlbp_gnt, data_gnt, inst_gnt}, 3'b010);
    check("tri_rv1", {tlbp_rvalid, data_rvalid, inst_rvalid}, 3'b100);
    cyc(0, 0, 1, 0, 0);
    @(negedge clk);
    check("tri_n2", {tlbp_gnt, data_gnt, inst_gnt}, 3'b001);
    check("tri_rv2", {tlbp_rvalid, data_rvalid, inst_rvalid}, 3'b010);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("tri_rv3", {tlbp_rvalid, data_rvalid, inst_rvalid}, 3'b001);

    // Starvation: inst loses LIMIT cycles to data, then wins once.
    for (int k = 0; k < LIMIT; k++) begin
      cyc(0, 0, 1, 1, 0);
      @(negedge clk);
      check("starve_lose", {data_gnt, inst_gnt}, 2'b10);
    end
    cyc(0, 0, 1, 1, 0);
    @(negedge clk);
    check("starve_win", {data_gnt, inst_gnt}, 2'b01);
    cyc(0, 0, 1, 1, 0);
    @(negedge clk);
    check("starve_reset", {data_gnt, inst_gnt}, 2'b10);

    // Flush kills inst result and grant; data proceeds.
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 0);
    @(negedge clk);
    check("flush_rv", inst_rvalid, 1'b0);
    check("flush_gnt", {data_gnt, inst_gnt}, 2'b10);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("flush_drv", data_rvalid, 1'b1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    @(negedge clk);
    check("flush_trv", tlbp_rvalid, 1'b1);

    // Reset right after a data grant discards its result.
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 1, 1, 1);
    @(negedge clk);
    check("rst_drv", data_rvalid, 1'b0);
    check("rst_rpfn", r_pfn, 20'd0);
    check("rst_gnt2", {tlbp_gnt, data_gnt, inst_gnt}, 3'b000);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("post_rst_rv", {tlbp_rvalid, data_rvalid, inst_rvalid}, 3'b000);

`ifdef TLB_ARB_PERF_EN
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    check("perf_conflict", perf_conflict, 32'd3);
    check("perf_starve", perf_starve, 32'd0);
`endif

    // Random tail, checked by the model alone.
    for (int k = 0; k < 80; k++) begin
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      inst_vpn = 19'($urandom_range(0, 31)) ^ 19'h00400;
      data_vpn = 19'($urandom);
      tlbp_odd = 1'($urandom_range(0, 1));
    end
    cyc(0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
